// File: rtl/pcu_pkg.sv
// Shared opcode constants, ALU-op encodings and the control bundle for the pipe control unit.
// PCU_JAL_EN adds the link control bit used by JAL.
package pcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       reg_dest;
        logic       branch_eq;
        logic       branch_ne;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
`ifdef PCU_JAL_EN
        logic       link;
`endif
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/pipe_control_unit_decode.sv
// Combinational opcode decoder: control bundle plus an illegal flag for undecoded opcodes.
// JAL decodes only when PCU_JAL_EN is defined; otherwise it is illegal.
module pcu_decode
    import pcu_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic [OPW-1:0] opcode,
    output ctrl_t          ctrl,
    output logic           illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OPW'(OP_RTYPE): begin
                ctrl.reg_dest  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OPW'(OP_ADDI): begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPW'(OP_LW): begin
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OPW'(OP_SW): begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OPW'(OP_BEQ): begin
                ctrl.branch_eq = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            OPW'(OP_BNE): begin
                ctrl.branch_ne = 1'b1;
                ctrl.alu_op    = ALU_SUB;
            end
            OPW'(OP_J): begin
                ctrl.jump = 1'b1;
            end
`ifdef PCU_JAL_EN
            OPW'(OP_JAL): begin
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.link      = 1'b1;
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control_unit.sv
// ID-stage control: decode into the ID/EX register, load-use bubble insertion, backpressure, flush.
// Define PCU_JAL_EN to add the link output and JAL decode.
module pipe_control_unit
    import pcu_pkg::*;
#(
    parameter int unsigned OPW    = 6,
    parameter int unsigned ALUOPW = 2,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OPW-1:0]    opcode,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic              reg_dest,
    output logic              branch_eq,
    output logic              branch_ne,
    output logic              mem_read,
    output logic              mem_to_reg,
    output logic              mem_write,
    output logic              alu_src,
    output logic              reg_write,
    output logic              jump,
`ifdef PCU_JAL_EN
    output logic              link,
`endif
    output logic [ALUOPW-1:0] alu_op,
    output logic [4:0]        ex_rt,
    output logic              stall,
    output logic              illegal,
    output logic [CNTW-1:0]   bubble_cnt
);

    typedef enum logic [0:0] {StRun, StLuBubble} state_e;

    state_e          state_q, state_d;
    ctrl_t           ctrl_q, ctrl_out, dec_ctrl;
    logic            dec_illegal;
    logic            out_valid_q, illegal_q;
    logic [4:0]      ex_rt_q;
    logic [CNTW-1:0] bubble_cnt_q;
    logic            hazard, hold, load_bubble;

    pcu_decode #(
        .OPW(OPW)
    ) u_decode (
        .opcode (opcode),
        .ctrl   (dec_ctrl),
        .illegal(dec_illegal)
    );

    assign hazard = in_valid & out_valid_q & ctrl_q.mem_read & (ex_rt_q != 5'd0)
                  & ((ex_rt_q == rs) | (ex_rt_q == rt));
    assign hold        = out_valid_q & ~ex_ready;
    // A bubble never carries a load, so the hazard can only fire from StRun.
    assign load_bubble = ~flush & ~hold & hazard & (state_q == StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StRun;
        end else if (load_bubble) begin
            state_d = StLuBubble;
        end else if (!hold) begin
            state_d = StRun;
        end
    end

    always_comb begin
        stall = ~flush & (hold | load_bubble);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            ex_rt_q      <= 5'd0;
            illegal_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            ex_rt_q     <= 5'd0;
            illegal_q   <= 1'b0;
        end else if (hold) begin
            illegal_q <= 1'b0;
        end else if (load_bubble) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= CTRL_NOP;
            ex_rt_q     <= 5'd0;
            illegal_q   <= 1'b0;
            if (bubble_cnt_q != {CNTW{1'b1}}) begin
                bubble_cnt_q <= bubble_cnt_q + CNTW'(1);
            end
        end else begin
            out_valid_q <= in_valid;
            ctrl_q      <= in_valid ? dec_ctrl : CTRL_NOP;
            ex_rt_q     <= in_valid ? rt : 5'd0;
            illegal_q   <= in_valid & dec_illegal;
        end
    end

    assign ctrl_out   = out_valid_q ? ctrl_q : CTRL_NOP;
    assign out_valid  = out_valid_q;
    assign reg_dest   = ctrl_out.reg_dest;
    assign branch_eq  = ctrl_out.branch_eq;
    assign branch_ne  = ctrl_out.branch_ne;
    assign mem_read   = ctrl_out.mem_read;
    assign mem_to_reg = ctrl_out.mem_to_reg;
    assign mem_write  = ctrl_out.mem_write;
    assign alu_src    = ctrl_out.alu_src;
    assign reg_write  = ctrl_out.reg_write;
    assign jump       = ctrl_out.jump;
`ifdef PCU_JAL_EN
    assign link       = ctrl_out.link;
`endif
    assign alu_op     = ALUOPW'(ctrl_out.alu_op);
    assign ex_rt      = ex_rt_q;
    assign illegal    = illegal_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: stimulus pushes expected ID/EX contents, a monitor
// pops them on each EX handshake. A second instance with CNTW=2 checks counter saturation.
module tb_pipe_control_unit;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_J    = 6'b000010;
    localparam logic [5:0] T_JAL  = 6'b000011;
    localparam logic [5:0] T_BAD  = 6'b111111;

    // Order: reg_dest beq bne mem_read mem_to_reg mem_write alu_src reg_write jump link
    localparam logic [9:0] C_R    = 10'b1000000100;
    localparam logic [9:0] C_ADDI = 10'b0000001100;
    localparam logic [9:0] C_LW   = 10'b0001101100;
    localparam logic [9:0] C_SW   = 10'b0000011000;
    localparam logic [9:0] C_BEQ  = 10'b0100000000;
    localparam logic [9:0] C_BNE  = 10'b0010000000;
    localparam logic [9:0] C_J    = 10'b0000000010;
    localparam logic [9:0] C_JAL  = 10'b0000000111;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       in_valid = 1'b0, ex_ready = 1'b1, flush = 1'b0;
    logic [5:0] opcode = '0;
    logic [4:0] rs = '0, rt = '0;

    logic        out_valid, reg_dest, branch_eq, branch_ne, mem_read, mem_to_reg, mem_write;
    logic        alu_src, reg_write, jump, link_w, stall, illegal;
    logic [1:0]  alu_op;
    logic [4:0]  ex_rt;
    logic [15:0] bubble_cnt;

    logic        s_out_valid, s_reg_dest, s_branch_eq, s_branch_ne, s_mem_read, s_mem_to_reg;
    logic        s_mem_write, s_alu_src, s_reg_write, s_jump, s_stall, s_illegal;
    logic [1:0]  s_alu_op;
    logic [4:0]  s_ex_rt;
    logic [1:0]  s_bubble_cnt;
`ifdef PCU_JAL_EN
    logic        s_link;
`endif

    logic [17:0] obs;
    logic [17:0] exp_q[$];
    int          n_total = 0, n_pass = 0;

    always #5 clk = ~clk;

    pipe_control_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid), .reg_dest(reg_dest),
        .branch_eq(branch_eq), .branch_ne(branch_ne), .mem_read(mem_read),
        .mem_to_reg(mem_to_reg), .mem_write(mem_write), .alu_src(alu_src),
        .reg_write(reg_write), .jump(jump),
`ifdef PCU_JAL_EN
        .link(link_w),
`endif
        .alu_op(alu_op), .ex_rt(ex_rt), .stall(stall), .illegal(illegal),
        .bubble_cnt(bubble_cnt)
    );

`ifndef PCU_JAL_EN
    assign link_w = 1'b0;
`endif

    pipe_control_unit #(.CNTW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .opcode(opcode), .rs(rs), .rt(rt),
        .ex_ready(ex_ready), .flush(flush), .out_valid(s_out_valid), .reg_dest(s_reg_dest),
        .branch_eq(s_branch_eq), .branch_ne(s_branch_ne), .mem_read(s_mem_read),
        .mem_to_reg(s_mem_to_reg), .mem_write(s_mem_write), .alu_src(s_alu_src),
        .reg_write(s_reg_write), .jump(s_jump),
`ifdef PCU_JAL_EN
        .link(s_link),
`endif
        .alu_op(s_alu_op), .ex_rt(s_ex_rt), .stall(s_stall), .illegal(s_illegal),
        .bubble_cnt(s_bubble_cnt)
    );

    assign obs = {reg_dest, branch_eq, branch_ne, mem_read, mem_to_reg, mem_write, alu_src,
                  reg_write, jump, link_w, alu_op, illegal, ex_rt};

    function automatic logic [17:0] ev(input logic [9:0] c, input logic [1:0] a,
                                       input logic il, input logic [4:0] r);
        return {c, a, il, r};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) $display("FAIL %s: got %0h, expected %0h", name, act, req);
        else n_pass++;
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [4:0] s,
                       input logic [4:0] t);
        in_valid = v;
        opcode   = op;
        rs       = s;
        rt       = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each EX handshake consumes one expected entry; idle register must read all-zero.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {14'd0, obs}, 32'hffffffff);
                end else begin
                    chk("handshake", {14'd0, obs}, {14'd0, exp_q.pop_front()});
                end
            end else if (!out_valid) begin
                chk("idle_zero", {14'd0, obs}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset_obs", {14'd0, obs}, 32'd0);
        chk("reset_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        #5 rst_n = 1'b1;

        // Load-use hazard
        drv(1, T_LW, 5'd1, 5'd5); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd5));
        #1 chk("lu_first_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("lu_lw_memread", {31'd0, mem_read}, 32'd1);
        drv(1, T_R, 5'd5, 5'd2);
        #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        chk("lu_bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("lu_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("lu_bubble_nostall", {31'd0, stall}, 32'd0);
        exp_q.push_back(ev(C_R, 2'b10, 0, 5'd2));
        tick();
        chk("lu_add_regdest", {31'd0, reg_dest}, 32'd1);
        chk("lu_add_aluop", {30'd0, alu_op}, 32'd2);

        // No false hazard on r0
        drv(1, T_LW, 5'd3, 5'd0); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd0));
        #1 chk("r0_lw_stall", {31'd0, stall}, 32'd0);
        tick();
        drv(1, T_R, 5'd0, 5'd0); exp_q.push_back(ev(C_R, 2'b10, 0, 5'd0));
        #1 chk("r0_add_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("r0_cnt", {16'd0, bubble_cnt}, 32'd1);

        // Backpressure holds BEQ
        drv(1, T_BEQ, 5'd1, 5'd2); exp_q.push_back(ev(C_BEQ, 2'b01, 0, 5'd2));
        tick();
        drv(1, T_BNE, 5'd3, 5'd4); ex_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall", {31'd0, stall}, 32'd1);
            chk("bp_beq", {31'd0, branch_eq}, 32'd1);
            tick();
        end
        chk("bp_bne_not_yet", {31'd0, branch_ne}, 32'd0);
        ex_ready = 1'b1; exp_q.push_back(ev(C_BNE, 2'b01, 0, 5'd4));
        #1 chk("bp_release_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("bp_bne", {31'd0, branch_ne}, 32'd1);

        // Flush while a load-use hazard is pending
        drv(1, T_LW, 5'd1, 5'd7); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd7));
        tick();
        drv(1, T_R, 5'd7, 5'd1); flush = 1'b1;
        #1 chk("fl_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_cnt", {16'd0, bubble_cnt}, 32'd1);
        drv(1, T_ADDI, 5'd7, 5'd1); exp_q.push_back(ev(C_ADDI, 2'b00, 0, 5'd1));
        #1 chk("fl_run_stall", {31'd0, stall}, 32'd0);
        tick();

        // Remaining decodes and illegal opcodes
        drv(1, T_SW, 5'd2, 5'd3); exp_q.push_back(ev(C_SW, 2'b00, 0, 5'd3));
        tick();
        drv(1, T_J, 5'd0, 5'd0); exp_q.push_back(ev(C_J, 2'b00, 0, 5'd0));
        tick();
        drv(1, T_BAD, 5'd0, 5'd0); exp_q.push_back(ev(10'd0, 2'b00, 1, 5'd0));
        tick();
        chk("ill_pulse", {31'd0, illegal}, 32'd1);
        drv(0, T_R, 5'd0, 5'd0);
        tick();
        chk("ill_cleared", {31'd0, illegal}, 32'd0);
        drv(1, T_JAL, 5'd0, 5'd0);
`ifdef PCU_JAL_EN
        exp_q.push_back(ev(C_JAL, 2'b00, 0, 5'd0));
`else
        exp_q.push_back(ev(10'd0, 2'b00, 1, 5'd0));
`endif
        tick();
        drv(0, T_R, 5'd0, 5'd0);
        tick();

        // Four more bubbles: 5 total, CNTW=2 instance saturates at 3
        for (int i = 0; i < 4; i++) begin
            drv(1, T_LW, 5'd1, 5'd9); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd9));
            tick();
            drv(1, T_R, 5'd9, 5'd9);
            #1 chk("sat_stall", {31'd0, stall}, 32'd1);
            tick();
            chk("sat_cnt_step", {16'd0, bubble_cnt}, 32'(2 + i));
            exp_q.push_back(ev(C_R, 2'b10, 0, 5'd9));
            tick();
        end
        chk("sat_cnt16", {16'd0, bubble_cnt}, 32'd5);
        chk("sat_cnt2", {30'd0, s_bubble_cnt}, 32'd3);

        // Reset in the middle of a bubble
        drv(1, T_LW, 5'd1, 5'd10); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd10));
        tick();
        drv(1, T_R, 5'd10, 5'd0);
        tick();
        chk("rst_pre_cnt", {16'd0, bubble_cnt}, 32'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_obs", {14'd0, obs}, 32'd0);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        #3 rst_n = 1'b1;
        drv(1, T_LW, 5'd2, 5'd3); exp_q.push_back(ev(C_LW, 2'b00, 0, 5'd3));
        #1 chk("rst_lw_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("rst_lw_ctrl", {27'd0, mem_read, mem_to_reg, alu_src, reg_write, reg_dest},
            32'b11110);
        chk("rst_lw_aluop", {30'd0, alu_op}, 32'd0);
        chk("rst_lw_cnt", {16'd0, bubble_cnt}, 32'd0);
        drv(0, T_R, 5'd0, 5'd0);
        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
